// File: rtl/de_mdu_issue_pkg.sv
// Shared definitions for the D/E issue stage: MDU op encodings and the
// "no exception" code.
package de_mdu_issue_pkg;

   typedef enum logic [3:0] {
      MDU_OP_NOPE  = 4'd0,
      MDU_OP_MULT  = 4'd1,
      MDU_OP_MULTU = 4'd2,
      MDU_OP_DIV   = 4'd3,
      MDU_OP_DIVU  = 4'd4,
      MDU_OP_MTHI  = 4'd5,
      MDU_OP_MTLO  = 4'd6,
      MDU_OP_MFHI  = 4'd7,
      MDU_OP_MFLO  = 4'd8
   } mdu_op_t;

   localparam logic [4:0]  EXC_NONE    = 5'd0;
   localparam logic [31:0] EXC_PC_BOOT = 32'h0000_4180;

endpackage

// File: rtl/de_mdu_issue_if.sv
// D/E issue bus: D-stage fields and control in, E-stage fields and stall out.
// The optional mdu_stall_cnt member exists only when MDU_STALL_CNT_EN is defined.
interface de_mdu_issue_if;

   logic        req;
   logic        other_stall;
   logic        mdu_busy;
   logic [31:0] d_pc;
   logic [31:0] d_instr;
   logic        d_bd;
   logic [4:0]  d_exc;
   logic [31:0] d_rs_val;
   logic [31:0] d_rt_val;
   logic [3:0]  d_mdu_op;
   logic        d_mdu_start;
   logic        d_mdu_use;

   logic        stall_d;
   logic [31:0] e_pc;
   logic [31:0] e_instr;
   logic        e_bd;
   logic [4:0]  e_exc;
   logic [31:0] e_d1;
   logic [31:0] e_d2;
   logic [3:0]  e_mdu_op;
   logic        e_mdu_start;
`ifdef MDU_STALL_CNT_EN
   logic [31:0] mdu_stall_cnt;
`endif

   // Master drives the D side (decode/CP0/MDU); slave is the issue register.
   modport master (
      output req, other_stall, mdu_busy, d_pc, d_instr, d_bd, d_exc,
             d_rs_val, d_rt_val, d_mdu_op, d_mdu_start, d_mdu_use,
      input  stall_d, e_pc, e_instr, e_bd, e_exc, e_d1, e_d2,
             e_mdu_op, e_mdu_start
`ifdef MDU_STALL_CNT_EN
      , input mdu_stall_cnt
`endif
   );

   modport slave (
      input  req, other_stall, mdu_busy, d_pc, d_instr, d_bd, d_exc,
             d_rs_val, d_rt_val, d_mdu_op, d_mdu_start, d_mdu_use,
      output stall_d, e_pc, e_instr, e_bd, e_exc, e_d1, e_d2,
             e_mdu_op, e_mdu_start
`ifdef MDU_STALL_CNT_EN
      , output mdu_stall_cnt
`endif
   );

endinterface

// File: rtl/de_mdu_issue_mdu_hazard_chk.sv
// MDU structural hazard: an instruction touching HI/LO must wait while the
// MDU is busy, or while a start sits in E (busy rises one cycle after start).
module de_mdu_issue_mdu_hazard_chk (
   input  logic i_mdu_use,
   input  logic i_mdu_busy,
   input  logic i_e_mdu_start,
   output logic o_mdu_stall
);

   // Pure combinational interlock.
   always_comb begin
      o_mdu_stall = i_mdu_use & (i_mdu_busy | i_e_mdu_start);
   end

endmodule

// File: rtl/de_mdu_issue.sv
// D/E pipeline register with MDU interlock. Flushes to EXC_PC on a CP0 request,
// inserts bubbles while D is stalled, and blocks MDU starts from faulting
// instructions. Optional feature: MDU_STALL_CNT_EN adds a saturating
// count of MDU stall cycles (not counted while req is high).
module de_mdu_issue
   import de_mdu_issue_pkg::*;
#(
   parameter logic [31:0] EXC_PC = EXC_PC_BOOT
) (
   input  logic            clk,
   input  logic            reset,
   de_mdu_issue_if.slave   bus
);

   logic        w_mdu_stall;
   logic        w_stall_d;

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_bd;
   logic [4:0]  r_exc;
   logic [31:0] r_d1;
   logic [31:0] r_d2;
   logic [3:0]  r_mdu_op;
   logic        r_mdu_start;

   de_mdu_issue_mdu_hazard_chk u_hazard (
      .i_mdu_use     (bus.d_mdu_use),
      .i_mdu_busy    (bus.mdu_busy),
      .i_e_mdu_start (r_mdu_start),
      .o_mdu_stall   (w_mdu_stall)
   );

   // Stall is deliberately not masked by req; the flush takes priority in the register.
   always_comb begin
      w_stall_d = w_mdu_stall | bus.other_stall;
   end

   // E register: reset > flush > bubble (keeps PC/BD for EPC) > load.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc        <= 32'd0;
         r_instr     <= 32'd0;
         r_bd        <= 1'b0;
         r_exc       <= EXC_NONE;
         r_d1        <= 32'd0;
         r_d2        <= 32'd0;
         r_mdu_op    <= MDU_OP_NOPE;
         r_mdu_start <= 1'b0;
      end else if (bus.req) begin
         r_pc        <= EXC_PC;
         r_instr     <= 32'd0;
         r_bd        <= 1'b0;
         r_exc       <= EXC_NONE;
         r_d1        <= 32'd0;
         r_d2        <= 32'd0;
         r_mdu_op    <= MDU_OP_NOPE;
         r_mdu_start <= 1'b0;
      end else if (w_stall_d) begin
         r_pc        <= bus.d_pc;
         r_instr     <= 32'd0;
         r_bd        <= bus.d_bd;
         r_exc       <= EXC_NONE;
         r_d1        <= 32'd0;
         r_d2        <= 32'd0;
         r_mdu_op    <= MDU_OP_NOPE;
         r_mdu_start <= 1'b0;
      end else begin
         r_pc        <= bus.d_pc;
         r_instr     <= bus.d_instr;
         r_bd        <= bus.d_bd;
         r_exc       <= bus.d_exc;
         r_d1        <= bus.d_rs_val;
         r_d2        <= bus.d_rt_val;
         if (bus.d_exc != EXC_NONE) begin
            r_mdu_op    <= MDU_OP_NOPE;
            r_mdu_start <= 1'b0;
         end else begin
            r_mdu_op    <= bus.d_mdu_op;
            r_mdu_start <= bus.d_mdu_start;
         end
      end
   end

   assign bus.stall_d     = w_stall_d;
   assign bus.e_pc        = r_pc;
   assign bus.e_instr     = r_instr;
   assign bus.e_bd        = r_bd;
   assign bus.e_exc       = r_exc;
   assign bus.e_d1        = r_d1;
   assign bus.e_d2        = r_d2;
   assign bus.e_mdu_op    = r_mdu_op;
   assign bus.e_mdu_start = r_mdu_start;

`ifdef MDU_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Saturating count of MDU-stall cycles outside of a flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= 32'd0;
      end else if (w_mdu_stall && !bus.req && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign bus.mdu_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_de_mdu_issue.sv
// Directed table-driven bench for de_mdu_issue plus hand sequences for the
// mult/mflo interlock and reset during a stall.
module tb_de_mdu_issue;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   de_mdu_issue_if bus_if ();

   de_mdu_issue #(.EXC_PC(32'h0000_4180)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        req, oth, busy;
      logic [31:0] pc, instr;
      logic        bd;
      logic [4:0]  exc;
      logic [31:0] rs, rt;
      logic [3:0]  op;
      logic        start, mduse;
      logic        x_stall;
      logic [31:0] x_pc, x_instr;
      logic        x_bd;
      logic [4:0]  x_exc;
      logic [31:0] x_d1, x_d2;
      logic [3:0]  x_op;
      logic        x_start;
   } vec_t;

   function automatic vec_t mk(
      input logic req, oth, busy, input logic [31:0] pc, instr, input logic bd,
      input logic [4:0] exc, input logic [31:0] rs, rt, input logic [3:0] op,
      input logic start, mduse, x_stall, input logic [31:0] x_pc, x_instr,
      input logic x_bd, input logic [4:0] x_exc, input logic [31:0] x_d1, x_d2,
      input logic [3:0] x_op, input logic x_start);
      vec_t v;
      v.req = req; v.oth = oth; v.busy = busy; v.pc = pc; v.instr = instr;
      v.bd = bd; v.exc = exc; v.rs = rs; v.rt = rt; v.op = op;
      v.start = start; v.mduse = mduse; v.x_stall = x_stall; v.x_pc = x_pc;
      v.x_instr = x_instr; v.x_bd = x_bd; v.x_exc = x_exc; v.x_d1 = x_d1;
      v.x_d2 = x_d2; v.x_op = x_op; v.x_start = x_start;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus_if.req         = v.req;
      bus_if.other_stall = v.oth;
      bus_if.mdu_busy    = v.busy;
      bus_if.d_pc        = v.pc;
      bus_if.d_instr     = v.instr;
      bus_if.d_bd        = v.bd;
      bus_if.d_exc       = v.exc;
      bus_if.d_rs_val    = v.rs;
      bus_if.d_rt_val    = v.rt;
      bus_if.d_mdu_op    = v.op;
      bus_if.d_mdu_start = v.start;
      bus_if.d_mdu_use   = v.mduse;
   endtask

   task automatic chk(input string name, input logic [138:0] act, input logic [138:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [138:0] e_act();
      return {bus_if.e_pc, bus_if.e_instr, bus_if.e_bd, bus_if.e_exc,
              bus_if.e_d1, bus_if.e_d2, bus_if.e_mdu_op, bus_if.e_mdu_start};
   endfunction

   function automatic logic [138:0] e_exp(input vec_t v);
      return {v.x_pc, v.x_instr, v.x_bd, v.x_exc, v.x_d1, v.x_d2, v.x_op, v.x_start};
   endfunction

   localparam logic [31:0] I_ADD   = 32'h0109_5020;
   localparam logic [31:0] I_MULT  = 32'h0022_0018;
   localparam logic [31:0] I_MULTU = 32'h0022_0019;
   localparam logic [31:0] I_DIV   = 32'h0022_001A;
   localparam logic [31:0] I_MFLO  = 32'h0000_5012;
   localparam logic [31:0] I_MTLO  = 32'h0020_0013;

   vec_t vecs[12];
   vec_t idle;

   initial begin
      int cnt;
      n_checks = 0;
      n_errors = 0;
      //            req oth bsy pc       instr    bd exc  rs      rt  op st us | stl x_pc     x_instr  bd exc d1      d2  op st
      vecs[0]  = mk(0,0,0, 32'h100, I_ADD,   0, 5'd0, 32'd11, 32'd22, 4'd0,0,0, 0, 32'h100, I_ADD,   0,5'd0, 32'd11, 32'd22,4'd0,0);
      vecs[1]  = mk(0,0,0, 32'h104, I_MULT,  0, 5'd0, 32'd3,  32'd5,  4'd1,1,1, 0, 32'h104, I_MULT,  0,5'd0, 32'd3,  32'd5, 4'd1,1);
      vecs[2]  = mk(0,0,0, 32'h108, I_MFLO,  1, 5'd0, 32'd7,  32'd9,  4'd8,0,1, 1, 32'h108, 32'd0,   1,5'd0, 32'd0,  32'd0, 4'd0,0);
      vecs[3]  = mk(0,0,1, 32'h108, I_MFLO,  1, 5'd0, 32'd7,  32'd9,  4'd8,0,1, 1, 32'h108, 32'd0,   1,5'd0, 32'd0,  32'd0, 4'd0,0);
      vecs[4]  = mk(0,0,0, 32'h108, I_MFLO,  1, 5'd0, 32'd7,  32'd9,  4'd8,0,1, 0, 32'h108, I_MFLO,  1,5'd0, 32'd7,  32'd9, 4'd8,0);
      vecs[5]  = mk(0,0,0, 32'h10C, I_MULTU, 0, 5'd10,32'd1,  32'd2,  4'd2,1,1, 0, 32'h10C, I_MULTU, 0,5'd10,32'd1,  32'd2, 4'd0,0);
      vecs[6]  = mk(0,1,0, 32'h110, I_DIV,   0, 5'd0, 32'd100,32'd7,  4'd3,1,1, 1, 32'h110, 32'd0,   0,5'd0, 32'd0,  32'd0, 4'd0,0);
      vecs[7]  = mk(0,0,0, 32'h110, I_DIV,   0, 5'd0, 32'd100,32'd7,  4'd3,1,1, 0, 32'h110, I_DIV,   0,5'd0, 32'd100,32'd7, 4'd3,1);
      vecs[8]  = mk(1,0,0, 32'h114, I_MTLO,  1, 5'd0, 32'hDEAD,32'd0, 4'd6,0,1, 1, 32'h4180,32'd0,   0,5'd0, 32'd0,  32'd0, 4'd0,0);
      vecs[9]  = mk(1,0,0, 32'h118, I_ADD,   1, 5'd3, 32'd4,  32'd6,  4'd0,0,0, 0, 32'h4180,32'd0,   0,5'd0, 32'd0,  32'd0, 4'd0,0);
      vecs[10] = mk(0,0,1, 32'h11C, I_ADD,   0, 5'd0, 32'd8,  32'd9,  4'd0,0,0, 0, 32'h11C, I_ADD,   0,5'd0, 32'd8,  32'd9, 4'd0,0);
      vecs[11] = mk(0,0,1, 32'h120, I_MFLO,  0, 5'd0, 32'd1,  32'd1,  4'd8,0,1, 1, 32'h120, 32'd0,   0,5'd0, 32'd0,  32'd0, 4'd0,0);
      idle     = mk(0,0,0, 32'h0,   32'h0,   0, 5'd0, 32'd0,  32'd0,  4'd0,0,0, 0, 32'h0,   32'h0,   0,5'd0, 32'd0,  32'd0, 4'd0,0);

      reset = 1'b1;
      drive(idle);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_e_outputs", e_act(), 139'd0);
      chk("reset_stall_d", {138'd0, bus_if.stall_d}, 139'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("vec%0d_stall_d", i), {138'd0, bus_if.stall_d}, {138'd0, vecs[i].x_stall});
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_e_fields", i), e_act(), e_exp(vecs[i]));
      end

      // mult then mflo with busy high for 5 cycles: expect exactly 6 stall cycles.
      @(negedge clk);
      reset = 1'b1;
      drive(idle);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      drive(vecs[1]);
      @(posedge clk);
      @(negedge clk);
      drive(vecs[2]);
      bus_if.d_bd = 1'b0;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (!bus_if.stall_d) break;
         cnt++;
         @(posedge clk);
         #1;
         chk("mflo_bubble", {bus_if.e_pc, bus_if.e_instr, bus_if.e_mdu_op, bus_if.e_mdu_start},
             {32'h108, 32'd0, 4'd0, 1'b0});
         @(negedge clk);
         bus_if.mdu_busy = (cnt <= 5);
      end
      chk("mflo_stall_cycles", 139'(cnt), 139'd6);
`ifdef MDU_STALL_CNT_EN
      chk("mdu_stall_cnt", 139'(bus_if.mdu_stall_cnt), 139'd6);
`endif
      @(posedge clk);
      #1;
      chk("mflo_issue", {bus_if.e_pc, bus_if.e_instr, bus_if.e_mdu_op, bus_if.e_d1, bus_if.e_d2},
          {32'h108, I_MFLO, 4'd8, 32'd7, 32'd9});

      // Reset while stalled: E returns to reset values; stall follows busy.
      @(negedge clk);
      drive(vecs[11]);
      #1;
      chk("rst_mid_stall_pre", {138'd0, bus_if.stall_d}, {138'd0, 1'b1});
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_stall_e", e_act(), 139'd0);
      chk("rst_mid_stall_hold", {138'd0, bus_if.stall_d}, {138'd0, 1'b1});
      @(negedge clk);
      reset = 1'b0;
      bus_if.mdu_busy = 1'b0;
      #1;
      chk("rst_mid_stall_release", {138'd0, bus_if.stall_d}, 139'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
